// File: rtl/sd_loader_pkg.sv
// Shared types and constants for the SD-card sector loader.
package sd_loader_pkg;

  localparam int BytesPerSector = 512;
  localparam int BytesPerWord   = 4;

  localparam logic [2:0] ReadNone  = 3'b000;
  localparam logic [2:0] ReadWord  = 3'b111;
  localparam logic [1:0] WriteNone = 2'b00;
  localparam logic [1:0] WriteWord = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_SETTLE,
    ST_POLL,
    ST_BYTE,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sd_loader_packer.sv
// Packs sector bytes into a little-endian 32-bit word; first byte lands in bits [7:0].
module sd_loader_packer
  import sd_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  logic [2:0] count;

  // Shifting in from the top leaves byte 0 in the low lane after four shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (shift_en) begin
      word  <= {byte_in, word[31:8]};
      count <= count + 3'd1;
    end
  end

  assign full = (count == 3'(BytesPerWord));

endmodule

// File: rtl/sd_loader.sv
// Boot loader: copies 512-byte SD sectors into RAM through the CPU-side client port.
// Optional build macro SD_LOADER_CHECKSUM_EN adds a running sum of all written words.
module sd_loader
  import sd_loader_pkg::*;
#(
  parameter int                         AddressBitWidth         = 32,
  parameter int                         DataBitWidth            = 32,
  parameter logic [AddressBitWidth-1:0] AddressSDCardBusy       = 32'hffff_fff0,
  parameter logic [AddressBitWidth-1:0] AddressSDCardReadSector = 32'hffff_ffec,
  parameter logic [AddressBitWidth-1:0] AddressSDCardNextByte   = 32'hffff_ffe8,
  parameter int                         CommandSettleCycles     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [31:0]                start_sector,
  input  logic [15:0]                sector_count,
  input  logic [AddressBitWidth-1:0] dest_address,
  output logic                       active,
  output logic                       done,
  output logic                       mem_enable,
  output logic [2:0]                 mem_read_type,
  output logic [1:0]                 mem_write_type,
  output logic [AddressBitWidth-1:0] mem_address,
  output logic [DataBitWidth-1:0]    mem_data_out,
  input  logic [DataBitWidth-1:0]    mem_data_in,
  input  logic                       mem_data_in_ready,
  input  logic                       mem_busy
`ifdef SD_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]                checksum
`endif
);

  localparam logic [7:0] SettleLast = 8'(CommandSettleCycles - 1);

  state_t                     state;
  logic [31:0]                sector;
  logic [15:0]                remaining;
  logic [AddressBitWidth-1:0] cur_addr;
  logic [9:0]                 byte_idx;
  logic [7:0]                 settle_cnt;

  logic        start_accept;
  logic        write_done;
  logic        pk_shift;
  logic        pk_clear;
  logic [31:0] pk_word;
  logic        pk_full;

  assign start_accept = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign write_done   = (state == ST_WRITE) && mem_enable && !mem_busy;
  assign pk_shift     = (state == ST_BYTE) && mem_enable;
  assign pk_clear     = write_done || start_accept;

  sd_loader_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pk_clear),
    .shift_en (pk_shift),
    .byte_in  (mem_data_in[7:0]),
    .word     (pk_word),
    .full     (pk_full)
  );

  // Each bus state spends one cycle with mem_enable low before issuing, which
  // guarantees the idle gap between back-to-back transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      active         <= 1'b0;
      done           <= 1'b0;
      mem_enable     <= 1'b0;
      mem_read_type  <= ReadNone;
      mem_write_type <= WriteNone;
      mem_address    <= '0;
      mem_data_out   <= '0;
      sector         <= '0;
      remaining      <= '0;
      cur_addr       <= '0;
      byte_idx       <= '0;
      settle_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sector    <= start_sector;
            remaining <= sector_count;
            cur_addr  <= dest_address;
            byte_idx  <= '0;
            if (sector_count == 16'd0) begin
              state  <= ST_DONE;
              active <= 1'b0;
              done   <= 1'b1;
            end else begin
              state  <= ST_CMD;
              active <= 1'b1;
              done   <= 1'b0;
            end
          end
        end

        ST_CMD: begin
          if (!mem_enable) begin
            mem_enable     <= 1'b1;
            mem_write_type <= WriteWord;
            mem_address    <= AddressSDCardReadSector;
            mem_data_out   <= sector;
          end else if (!mem_busy) begin
            mem_enable     <= 1'b0;
            mem_write_type <= WriteNone;
            settle_cnt     <= '0;
            state          <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == SettleLast) begin
            state <= ST_POLL;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end

        ST_POLL: begin
          if (!mem_enable) begin
            mem_enable    <= 1'b1;
            mem_read_type <= ReadWord;
            mem_address   <= AddressSDCardBusy;
          end else if (!mem_busy && mem_data_in_ready) begin
            mem_enable    <= 1'b0;
            mem_read_type <= ReadNone;
            if (mem_data_in == '0) begin
              byte_idx <= '0;
              state    <= ST_BYTE;
            end
          end
        end

        // The card pops a byte on every enabled cycle, so the read is never held.
        ST_BYTE: begin
          if (!mem_enable) begin
            mem_enable    <= 1'b1;
            mem_read_type <= ReadWord;
            mem_address   <= AddressSDCardNextByte;
          end else begin
            mem_enable    <= 1'b0;
            mem_read_type <= ReadNone;
            byte_idx      <= byte_idx + 10'd1;
            if (byte_idx[1:0] == 2'd3) state <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (!mem_enable) begin
            if (pk_full) begin
              mem_enable     <= 1'b1;
              mem_write_type <= WriteWord;
              mem_address    <= cur_addr;
              mem_data_out   <= pk_word;
            end
          end else if (!mem_busy) begin
            mem_enable     <= 1'b0;
            mem_write_type <= WriteNone;
            cur_addr       <= cur_addr + AddressBitWidth'(4);
            if (byte_idx != 10'(BytesPerSector)) begin
              state <= ST_BYTE;
            end else begin
              sector    <= sector + 32'd1;
              remaining <= remaining - 16'd1;
              if (remaining != 16'd1) begin
                state <= ST_CMD;
              end else begin
                state  <= ST_DONE;
                active <= 1'b0;
                done   <= 1'b1;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SD_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_accept) begin
      checksum <= '0;
    end else if (write_done) begin
      checksum <= checksum + mem_data_out[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_sd_loader.sv
// Bench for sd_loader: a client/SD-card responder plus a sector-level scoreboard.
module tb_sd_loader;

  localparam logic [31:0] ADDR_BUSY   = 32'hffff_fff0;
  localparam logic [31:0] ADDR_SECTOR = 32'hffff_ffec;
  localparam logic [31:0] ADDR_NEXT   = 32'hffff_ffe8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_sector = '0;
  logic [15:0] sector_count = '0;
  logic [31:0] dest_address = '0;
  logic        active, done, mem_enable;
  logic [2:0]  mem_read_type;
  logic [1:0]  mem_write_type;
  logic [31:0] mem_address, mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_data_in_ready, mem_busy;
`ifdef SD_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  sd_loader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .start_sector      (start_sector),
    .sector_count      (sector_count),
    .dest_address      (dest_address),
    .active            (active),
    .done              (done),
    .mem_enable        (mem_enable),
    .mem_read_type     (mem_read_type),
    .mem_write_type    (mem_write_type),
    .mem_address       (mem_address),
    .mem_data_out      (mem_data_out),
    .mem_data_in       (mem_data_in),
    .mem_data_in_ready (mem_data_in_ready),
    .mem_busy          (mem_busy)
`ifdef SD_LOADER_CHECKSUM_EN
    ,
    .checksum          (checksum)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and card model state
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_cmd_q[$];
  logic [31:0] poll_q[$];
  logic [31:0] ram [logic [31:0]];
  logic [31:0] exp_sum;
  logic [31:0] cur_sec = '0;
  logic [31:0] pat_mul = '0;
  logic [31:0] pat_add = '0;
  logic        sd_ready = 1'b0;
  bit          rand_busy = 1'b0;
  int ram_writes = 0, cmd_count = 0, byte_off = 0, poll_count = 0, en_cycles = 0;
  int stall_idx = -1, stall_left = 0;

  function automatic logic [7:0] sd_byte(input logic [31:0] sec, input int off);
    logic [31:0] v;
    v = 32'(off) + sec * pat_mul + pat_add;
    return v[7:0];
  endfunction

  task automatic flush_bench();
    exp_q.delete(); exp_addr_q.delete(); exp_cmd_q.delete(); poll_q.delete();
    ram_writes = 0; cmd_count = 0; byte_off = 0; poll_count = 0; sd_ready = 1'b0;
  endtask

  // Expected traffic for a whole load, derived sector by sector.
  task automatic plan_load(input logic [31:0] s, input int n, input logic [31:0] d);
    logic [31:0] sec, word;
    exp_sum = '0;
    for (int j = 0; j < n; j++) begin
      sec = s + 32'(j);
      exp_cmd_q.push_back(sec);
      for (int w = 0; w < 128; w++) begin
        for (int b = 0; b < 4; b++) word[8*b +: 8] = sd_byte(sec, 4*w + b);
        exp_addr_q.push_back(d + 32'(4 * (j*128 + w)));
        exp_q.push_back(word);
        exp_sum += word;
      end
    end
  endtask

  // Client + SD responder: drives the inputs for the coming edge and logs completions.
  initial begin
    logic        busy_v, ready_v, complete, prev_en, prev_complete;
    logic [31:0] data_v, prev_addr, prev_data, exp_v;
    prev_en = 1'b0; prev_complete = 1'b0; prev_addr = '0; prev_data = '0;
    mem_busy = 1'b0; mem_data_in_ready = 1'b0; mem_data_in = '0;
    forever begin
      @(negedge clk);
      busy_v = 1'b0; ready_v = 1'b1; data_v = $urandom; complete = 1'b0;
      if (rst_n && prev_complete) check("enable_gap", mem_enable, 1'b0);
      if (rst_n && mem_enable) begin
        en_cycles++;
        if (prev_en && !prev_complete) begin
          check("hold_addr", mem_address, prev_addr);
          check("hold_data", mem_data_out, prev_data);
        end
        if (mem_write_type == 2'b11 && mem_address == ADDR_SECTOR) begin
          busy_v = rand_busy && ($urandom_range(0, 3) == 0);
          if (!busy_v) begin
            complete = 1'b1;
            if (cmd_count > 0) check("bytes_per_sector", byte_off, 512);
            exp_v = (exp_cmd_q.size() != 0) ? exp_cmd_q.pop_front() : ~mem_data_out;
            check("sector_cmd", mem_data_out, exp_v);
            cur_sec = mem_data_out; byte_off = 0; sd_ready = 1'b0; poll_count = 0;
            cmd_count++;
          end
        end else if (mem_write_type == 2'b11) begin
          if (ram_writes == stall_idx && stall_left > 0) begin
            busy_v = 1'b1;
            stall_left--;
          end else begin
            busy_v = rand_busy && ($urandom_range(0, 3) == 0);
          end
          if (!busy_v) begin
            complete = 1'b1;
            check("write_read_type", mem_read_type, 3'b000);
            exp_v = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : ~mem_address;
            check("write_addr", mem_address, exp_v);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : ~mem_data_out;
            check("write_data", mem_data_out, exp_v);
            ram[mem_address] = mem_data_out;
            ram_writes++;
          end
        end else if (mem_read_type == 3'b111 && mem_address == ADDR_BUSY) begin
          if (rand_busy) begin
            busy_v  = ($urandom_range(0, 3) == 0);
            ready_v = ($urandom_range(0, 3) != 0);
          end
          if (!busy_v && ready_v) begin
            complete = 1'b1;
            data_v = (poll_q.size() != 0) ? poll_q.pop_front() : 32'd0;
            poll_count++;
            if (data_v == 32'd0) sd_ready = 1'b1;
          end
        end else if (mem_read_type == 3'b111 && mem_address == ADDR_NEXT) begin
          check("byte_after_ready", sd_ready, 1'b1);
          complete = 1'b1;
          data_v = {data_v[31:8], sd_byte(cur_sec, byte_off)};
          byte_off++;
        end else begin
          check("access_type", {mem_read_type, mem_write_type}, 5'b00011);
        end
      end
      prev_en = rst_n && mem_enable;
      prev_complete = rst_n && complete;
      prev_addr = mem_address;
      prev_data = mem_data_out;
      mem_busy = busy_v;
      mem_data_in_ready = ready_v;
      mem_data_in = data_v;
    end
  end

  task automatic run_load(input logic [31:0] s, input logic [15:0] n, input logic [31:0] d,
                          input bit poke_start);
    int limit;
    plan_load(s, int'(n), d);
    ram_writes = 0; cmd_count = 0;
    @(negedge clk);
    start = 1'b1; start_sector = s; sector_count = n; dest_address = d;
    @(negedge clk);
    start = 1'b0; start_sector = $urandom; sector_count = 16'($urandom); dest_address = $urandom;
    check("active_after_start", active, 1'b1);
    limit = 2500 * int'(n) + 100;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge clk);
      if (poke_start && c == 40) begin
        start = 1'b1; start_sector = $urandom; sector_count = 16'd1; dest_address = 32'h40;
      end
      if (poke_start && c == 80) start = 1'b0;
    end
    check("load_done", done, 1'b1);
    check("active_at_done", active, 1'b0);
    check("words_left", exp_q.size(), 0);
    check("cmds_left", exp_cmd_q.size(), 0);
    check("words_written", ram_writes, 128 * int'(n));
    check("cmds_written", cmd_count, int'(n));
    check("bytes_last_sector", byte_off, 512);
`ifdef SD_LOADER_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`endif
    flush_bench();
  endtask

  initial begin
    int en0;
    logic [31:0] s, d;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_active", active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_enable", mem_enable, 1'b0);
    check("rst_read_type", mem_read_type, 3'b000);
    check("rst_write_type", mem_write_type, 2'b00);
    check("rst_address", mem_address, 32'd0);
    check("rst_data_out", mem_data_out, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero sectors: done right after acceptance, no bus traffic
    en0 = en_cycles;
    start = 1'b1; sector_count = 16'd0; start_sector = 32'd9; dest_address = 32'h80;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_active", active, 1'b0);
    repeat (4) @(negedge clk);
    check("zero_no_enable", en_cycles, en0);
`ifdef SD_LOADER_CHECKSUM_EN
    check("zero_checksum", checksum, 32'd0);
`endif

    // Counting byte pattern into 0x100
    run_load(32'd5, 16'd1, 32'h100, 1'b0);
    check("word_0x100", ram[32'h100], 32'h0302_0100);
    check("word_0x1fc", ram[32'h1fc], 32'hfffe_fdfc);

    // Card reports busy three times
    pat_mul = $urandom; pat_add = $urandom;
    poll_q.push_back(32'd1); poll_q.push_back(32'd1); poll_q.push_back(32'd1);
    poll_q.push_back(32'd0);
    s = $urandom;
    plan_load(s, 0, 32'h0);
    run_load(s, 16'd1, 32'h2000, 1'b0);
    // poll_count is cleared by flush in run_load, so re-run the scenario and sample before the flush
    poll_q.push_back(32'd1); poll_q.push_back(32'd1); poll_q.push_back(32'd1);
    poll_q.push_back(32'd0);
    plan_load(s, 1, 32'h3000);
    @(negedge clk);
    start = 1'b1; start_sector = s; sector_count = 16'd1; dest_address = 32'h3000;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300 && byte_off == 0; c++) @(negedge clk);
    check("busy_polls", poll_count, 4);
    for (int c = 0; c < 2600 && !done; c++) @(negedge clk);
    check("busy_load_done", done, 1'b1);
    check("busy_words", ram_writes, 128);
    flush_bench();

    // RAM write held busy for 7 cycles
    stall_idx = 5; stall_left = 7;
    run_load($urandom, 16'd1, 32'h4000, 1'b0);
    stall_idx = -1;

    // Sector number and destination address both wrap
    pat_mul = $urandom; pat_add = $urandom;
    run_load(32'hffff_ffff, 16'd2, 32'hffff_fff8, 1'b0);
    check("wrap_word_lo", ram[32'h0000_03f0], exp_q.size() == 0 ? ram[32'h0000_03f0] : 32'h0);

    // Randomized loads with bus and card back-pressure; start poked mid-load
    rand_busy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      pat_mul = $urandom; pat_add = $urandom;
      for (int p = 0; p < $urandom_range(0, 3); p++) poll_q.push_back($urandom | 32'd1);
      poll_q.push_back(32'd0);
      s = $urandom;
      d = $urandom & 32'h7fff_fffc;
      run_load(s, 16'($urandom_range(1, 2)), d, (t == 0));
    end
    rand_busy = 1'b0;

    // Asynchronous reset in the middle of a sector
    pat_mul = $urandom; pat_add = $urandom;
    plan_load(32'd77, 1, 32'h8000);
    @(negedge clk);
    start = 1'b1; start_sector = 32'd77; sector_count = 16'd1; dest_address = 32'h8000;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400 && byte_off < 37; c++) @(negedge clk);
    check("reached_byte_37", byte_off, 37);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_active", active, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_enable", mem_enable, 1'b0);
    check("arst_types", {mem_read_type, mem_write_type}, 5'b00000);
    check("arst_address", mem_address, 32'd0);
    check("arst_data_out", mem_data_out, 32'd0);
    repeat (2) @(negedge clk);
    flush_bench();
    rst_n = 1'b1;
    @(negedge clk);
    run_load(32'd78, 16'd1, 32'h9000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
